sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_padder.sv | 202 ++++++++++++++++++++
 tb/tb_sha256_padder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// -----------------------------------------------------------------------------
// sha256_padder
//   Streams a byte message (32-bit AXI-Stream style input) and emits it as
//   padded SHA-256 512-bit blocks, one 32-bit word per output transfer, each
//   tagged with its word index inside the block so it can be written straight
//   into a hash core's block registers (0x10 + m_idx).
//
//   Padding appended after the message: one 0x80 byte, zero bytes up to block
//   byte 56, then the 64-bit big-endian message length in bits.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   s_tdata[31:0]         message word, byte i in bits [8i+7:8i]
//   s_tkeep[3:0]          valid bytes (1111 except on the last word)
//   s_tlast               last word of the message
//   s_tvalid / s_tready   input handshake
//   m_word[31:0]          block word, same byte packing as s_tdata
//   m_idx[3:0]            word index 0..15 within the current block
//   m_last                word 15 of the final block
//   m_valid / m_ready     output handshake
//   busy                  first accepted word .. final m_last transfer
// -----------------------------------------------------------------------------
module sha256_padder (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_tdata,
    input  logic [3:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_word,
    output logic [3:0]  m_idx,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PAD80  = 3'd2;
    localparam logic [2:0] S_ZERO   = 3'd3;
    localparam logic [2:0] S_LEN_HI = 3'd4;
    localparam logic [2:0] S_LEN_LO = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] word_q,  word_d;
    logic [3:0]  idx_q,   idx_d;
    logic        last_q,  last_d;
    logic        valid_q, valid_d;
    logic        busy_q,  busy_d;
    logic [3:0]  nidx_q,  nidx_d;   // index the next emitted word will carry
    logic [63:0] len_q,   len_d;    // message length in bits, wraps mod 2^64

    logic        load_ok;
    logic [2:0]  keep_cnt;
    logic [31:0] pad_word;
    logic [2:0]  after_pad;
    logic        emit;
    logic [31:0] emit_word;
    logic        emit_last;

    // Output register may take a new word when empty or being drained now.
    assign load_ok  = !valid_q || m_ready;
    assign s_tready = (state_q == S_DATA) && load_ok;

    assign keep_cnt = {2'b00, s_tkeep[0]} + {2'b00, s_tkeep[1]}
                    + {2'b00, s_tkeep[2]} + {2'b00, s_tkeep[3]};

    // Once the 0x80 byte has gone out, zero words run until the next emitted
    // index would be 14. Decided at emit time from the index being emitted,
    // so a 0x80 in word 14/15 naturally rolls into a second block.
    assign after_pad = (nidx_q == 4'd13) ? S_LEN_HI : S_ZERO;

    // Last partial word: kept bytes, then 0x80, then zeros.
    always_comb begin
        pad_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < keep_cnt) begin
                pad_word[8*i +: 8] = s_tdata[8*i +: 8];
            end else if (3'(i) == keep_cnt) begin
                pad_word[8*i +: 8] = 8'h80;
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        last_d    = last_q;
        valid_d   = valid_q && !m_ready;
        busy_d    = busy_q;
        nidx_d    = nidx_q;
        len_d     = len_q;
        emit      = 1'b0;
        emit_word = '0;
        emit_last = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s_tvalid) state_d = S_DATA;
            end
            S_DATA: begin
                if (s_tvalid && s_tready) begin
                    busy_d = 1'b1;
                    emit   = 1'b1;
                    if (!s_tlast) begin
                        emit_word = s_tdata;
                        len_d     = len_q + 64'd32;
                    end else begin
                        len_d = len_q + {58'd0, keep_cnt, 3'b000};
                        if (keep_cnt == 3'd4) begin
                            emit_word = s_tdata;
                            state_d   = S_PAD80;
                        end else begin
                            emit_word = pad_word;
                            state_d   = after_pad;
                        end
                    end
                end
            end
            S_PAD80: begin
                if (load_ok) begin
                    emit      = 1'b1;
                    emit_word = 32'h0000_0080;
                    state_d   = after_pad;
                end
            end
            S_ZERO: begin
                if (load_ok) begin
                    emit    = 1'b1;
                    state_d = after_pad;
                end
            end
            S_LEN_HI: begin
                if (load_ok) begin
                    emit      = 1'b1;
                    emit_word = {len_q[39:32], len_q[47:40], len_q[55:48], len_q[63:56]};
                    state_d   = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                // First visit emits the final word; then wait for it to drain.
                if (last_q) begin
                    if (load_ok) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        len_d   = '0;
                        nidx_d  = '0;
                    end
                end else if (load_ok) begin
                    emit      = 1'b1;
                    emit_word = {len_q[7:0], len_q[15:8], len_q[23:16], len_q[31:24]};
                    emit_last = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            word_d  = emit_word;
            idx_d   = nidx_q;
            last_d  = emit_last;
            valid_d = 1'b1;
            nidx_d  = nidx_q + 4'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            nidx_q  <= '0;
            len_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from the same
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            nidx_q  <= nidx_d;
            len_q   <= len_d;
        end
    end

    assign m_word  = word_q;
    assign m_idx   = idx_q;
    assign m_last  = last_q;
    assign m_valid = valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_sha256_padder.sv
// -----------------------------------------------------------------------------
// tb_sha256_padder
//   Self-checking bench for sha256_padder. A message-level model pads each
//   byte queue (0x80, zeros to byte 56 mod 64, 64-bit big-endian bit length)
//   and slices it into expected (word, idx, last) entries; a negedge monitor
//   checks every output transfer, output stability under back-pressure and
//   busy. Directed messages pin the model with literal words.
// -----------------------------------------------------------------------------
module tb_sha256_padder;

    logic        aclk     = 1'b0;
    logic        areset   = 1'b0;
    logic [31:0] s_tdata  = '0;
    logic [3:0]  s_tkeep  = '0;
    logic        s_tlast  = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_word;
    logic [3:0]  m_idx;
    logic        m_last;
    logic        m_valid;
    logic        m_ready  = 1'b1;
    logic        busy;

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  i;
        logic        l;
    } xfer_t;

    xfer_t      exp_q[$];
    xfer_t      got[$];
    logic [7:0] msg_q[$];

    int    checks     = 0;
    int    errors     = 0;
    bit    rand_ready = 1'b0;
    bit    gaps       = 1'b0;
    bit    exp_busy   = 1'b0;
    bit    prev_stall = 1'b0;
    xfer_t prev_out;

    sha256_padder dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_word   (m_word),
        .m_idx    (m_idx),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Output back-pressure, changed just after each rising edge.
    always @(posedge aclk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: values seen at the falling edge are what the next rising edge samples.
    always @(negedge aclk) begin
        xfer_t e;
        if (areset) begin
            exp_busy   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("busy", 64'(busy), 64'(exp_busy));
            if (prev_stall) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_hold", 64'({m_word, m_idx, m_last}), 64'(prev_out));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_xfer", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("m_word", 64'(m_word), 64'(e.w));
                    check("m_idx", 64'(m_idx), 64'(e.i));
                    check("m_last", 64'(m_last), 64'(e.l));
                    got.push_back('{w: m_word, i: m_idx, l: m_last});
                end
            end
            if (s_tvalid && s_tready) exp_busy = 1'b1;
            if (m_valid && m_ready && m_last) exp_busy = 1'b0;
            prev_stall = m_valid && !m_ready;
            prev_out   = '{w: m_word, i: m_idx, l: m_last};
        end
    end

    // Message-level reference: pad the byte stream, then cut into words.
    task automatic push_expected();
        logic [7:0]  p[$];
        logic [63:0] len_bits;
        int          total;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        len_bits = 64'(msg_q.size()) * 64'd8;
        for (int b = 7; b >= 0; b--) p.push_back(len_bits[8*b +: 8]);
        total = p.size() / 4;
        for (int n = 0; n < total; n++) begin
            xfer_t e;
            e.w = {p[4*n+3], p[4*n+2], p[4*n+1], p[4*n]};
            e.i = 4'(n % 16);
            e.l = (n == total - 1);
            exp_q.push_back(e);
        end
    endtask

    // Bytes past the end of the message are random so masking is exercised.
    function automatic logic [31:0] pack_word(input int n);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) begin
            if (4*n + b < msg_q.size()) w[8*b +: 8] = msg_q[4*n + b];
            else                        w[8*b +: 8] = 8'($urandom);
        end
        return w;
    endfunction

    // Called and returns #1 after a rising edge.
    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic last);
        int waited = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_tready && waited < 1000) begin
            @(negedge aclk);
            waited++;
        end
        check("s_tready_wait", 64'(s_tready), 64'd1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge aclk);
                #1;
            end
        end
    endtask

    // extra: a length that is a multiple of 4 ends with a tkeep=0000 last word.
    task automatic send_msg(input bit extra);
        int len   = msg_q.size();
        int nfull = len / 4;
        int rem   = len % 4;
        push_expected();
        for (int n = 0; n < nfull; n++)
            send_word(pack_word(n), 4'hF, (rem == 0) && !extra && (n == nfull - 1));
        if (rem != 0 || len == 0 || extra)
            send_word(pack_word(nfull), 4'((1 << rem) - 1), 1'b1);
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 5000) begin
            @(posedge aclk);
            waited++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic check_hello();
        logic [31:0] ref_w[16];
        ref_w = '{32'h6c6c6568, 32'h6f77206f, 32'h80646c72, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h58000000};
        check("hello_count", 64'(got.size()), 64'd16);
        if (got.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("hello_w%0d", i), 64'(got[i].w), 64'(ref_w[i]));
                check($sformatf("hello_l%0d", i), 64'(got[i].l), 64'(i == 15));
            end
        end
    endtask

    task automatic load_hello();
        msg_q = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64};
    endtask

    initial begin
        #1 areset = 1'b1;
        #1;
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_word", 64'(m_word), 64'd0);
        check("rst_idx", 64'(m_idx), 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;

        // "hello world" with random output back-pressure
        rand_ready = 1'b1;
        got.delete();
        load_hello();
        send_msg(1'b0);
        wait_drain();
        check_hello();

        // empty message
        rand_ready = 1'b0;
        got.delete();
        msg_q.delete();
        send_msg(1'b0);
        wait_drain();
        check("empty_count", 64'(got.size()), 64'd16);
        if (got.size() == 16) begin
            check("empty_w0", 64'(got[0].w), 64'h80);
            check("empty_w14", 64'(got[14].w), 64'h0);
            check("empty_w15", 64'({got[15].w, got[15].l}), 64'({32'h0, 1'b1}));
        end

        // 55 bytes: 0x80 lands in byte 3 of word 13, one block
        got.delete();
        msg_q.delete();
        for (int j = 0; j < 55; j++) msg_q.push_back(8'(j + 1));
        send_msg(1'b0);
        wait_drain();
        check("b55_count", 64'(got.size()), 64'd16);
        if (got.size() == 16) begin
            check("b55_w13", 64'(got[13].w), 64'h80373635);
            check("b55_w14", 64'(got[14].w), 64'h0);
            check("b55_w15", 64'({got[15].w, got[15].l}), 64'({32'hB8010000, 1'b1}));
        end

        // 56 bytes: spills into a second block, random back-pressure
        rand_ready = 1'b1;
        got.delete();
        msg_q.delete();
        for (int j = 0; j < 56; j++) msg_q.push_back(8'(j + 1));
        send_msg(1'b0);
        wait_drain();
        check("b56_count", 64'(got.size()), 64'd32);
        if (got.size() == 32) begin
            check("b56_w14", 64'(got[14].w), 64'h80);
            check("b56_w15", 64'({got[15].w, got[15].l}), 64'({32'h0, 1'b0}));
            check("b56_w16_idx", 64'(got[16].i), 64'd0);
            check("b56_w30", 64'(got[30].w), 64'h0);
            check("b56_w31", 64'({got[31].w, got[31].l}), 64'({32'hC0010000, 1'b1}));
        end

        // reset after 5 words of a message, then "hello world"
        rand_ready = 1'b0;
        msg_q.delete();
        for (int j = 0; j < 20; j++) msg_q.push_back(8'($urandom));
        for (int n = 0; n < 5; n++) exp_q.push_back('{w: pack_word(n), i: 4'(n), l: 1'b0});
        for (int n = 0; n < 5; n++)
            send_word({msg_q[4*n+3], msg_q[4*n+2], msg_q[4*n+1], msg_q[4*n]}, 4'hF, 1'b0);
        wait_drain();
        check("pre_rst_busy", 64'(busy), 64'd1);
        areset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(m_valid), 64'd0);
        check("mid_rst_word", 64'(m_word), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_tready", 64'(s_tready), 64'd0);
        repeat (2) @(posedge aclk);
        check("in_rst_busy", 64'(busy), 64'd0);
        #1 areset = 1'b0;
        got.delete();
        load_hello();
        send_msg(1'b0);
        wait_drain();
        check_hello();

        // random back-to-back messages with input gaps and back-pressure
        rand_ready = 1'b1;
        gaps       = 1'b1;
        for (int m = 0; m < 25; m++) begin
            msg_q.delete();
            repeat ($urandom_range(0, 130)) msg_q.push_back(8'($urandom));
            send_msg(1'($urandom_range(0, 1)));
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
